// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: handshake bundle for the elastic pipeline stage register.
//
// Signals:
//   flush      upstream -> stage  discard all held entries this cycle
//   in_valid   upstream -> stage  payload valid
//   in_ready   stage -> upstream  stage can accept (registered)
//   in_data    upstream -> stage  payload, WIDTH bits
//   out_valid  stage -> down      main entry valid
//   out_ready  down -> stage      downstream accepts
//   out_data   stage -> down      main entry payload, WIDTH bits
//   occupancy  stage -> observer  entries held (0, 1 or 2)
//   stall_cnt  stage -> observer  saturating stall counter, 16 bits
//                                 (present only with PIPE_SKID_STALL_CNT_EN)
//
// Modports: slave is the stage itself, master is the environment around it.
// Optional feature macro: PIPE_SKID_STALL_CNT_EN.

interface pipe_skid_reg_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    modport slave (
        input  flush, in_valid, in_data, out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
        output stall_cnt,
`endif
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline stage (main + skid) for the RV32I
// pipeline. Sustains one transfer per cycle while in_ready depends only on
// registered state. Supports flush for branch/jump redirect.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   pipe_skid_reg_if.slave: flush, in_valid/in_ready/in_data,
//         out_valid/out_ready/out_data, occupancy[1:0]
//         (+ stall_cnt[15:0] with PIPE_SKID_STALL_CNT_EN)
//
// Parameters:
//   WIDTH  payload width in bits (min 1), must match the interface WIDTH
//
// Optional feature macro: PIPE_SKID_STALL_CNT_EN adds a 16-bit saturating
// count of cycles with out_valid=1 and out_ready=0, cleared only by rst.

module pipe_skid_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipe_skid_reg_if.slave      bus
);

    // Encoding doubles as occupancy.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (bus.flush) begin
            // Data registers keep their contents; out_data is don't-care
            // while out_valid is low.
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_q      <= bus.in_data;
                        state_q     <= StFull;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                StFull: begin
                    if (in_fire && out_fire) begin
                        main_q <= bus.in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the newcomer behind main.
                        skid_q     <= bus.in_data;
                        state_q    <= StSkid;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StSkid: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state_q    <= StFull;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Flush does not touch the counter; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline stage register for the RV32I pipeline.
- Consumes the stage outputs produced by the plain flip-flop register primitives, e.g. fetched instruction plus PC, and feeds the next stage with a valid/ready handshake.
- Holds two entries (main + skid), so it sustains 1 transfer/cycle while keeping in_ready a pure function of registered state.
- Supports pipeline flush for branch/jump redirect.

Parameters:
- WIDTH, 32, payload width in bits (min 1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- flush  input  1  discard all held entries this cycle
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept; registered, depends only on state
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  main entry valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  main entry payload, driven directly from a register
- occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Handshake rules:
  - in fire = in_valid & in_ready; out fire = out_valid & out_ready.
  - Both are sampled at the rising edge of clk.
- Reset (rst=1 at edge): state EMPTY; main and skid data = 0; out_valid=0, in_ready=1, occupancy=0. This applies even mid-transfer.
- States and transitions (priority: rst > flush > handshake):
  - EMPTY (occ 0, in_ready=1, out_valid=0):
    - in fire -> main<=in_data, go FULL.
  - FULL (occ 1, in_ready=1, out_valid=1):
    - in fire & out fire -> main<=in_data, stay FULL.
    - in fire only -> skid<=in_data, go SKID.
    - out fire only -> EMPTY.
    - neither -> hold.
  - SKID (occ 2, in_ready=0, out_valid=1):
    - out fire -> main<=skid, go FULL.
    - else hold.
    - in_valid is ignored.
- Latency and throughput:
  - Payload accepted at edge N is visible on out_data/out_valid after edge N (1 cycle).
  - Steady-state throughput is 1/cycle when out_ready is held at 1.
- Ordering: strictly FIFO; skid data never overtakes main.
- Flush (flush=1 at edge, rst=0):
  - State goes to EMPTY, occupancy=0, out_valid=0, in_ready=1 next cycle.
  - A same-cycle in fire is accepted by upstream but discarded.
  - A same-cycle out fire still counts as consumed by downstream.
  - Data registers are not cleared by flush; out_data is don't-care while out_valid=0.
- Data stability:
  - out_data and out_valid hold constant while out_valid=1 and out_ready=0.
  - Main/skid registers load only on the transitions listed above.
- occupancy equals the state encoding: EMPTY=0, FULL=1, SKID=2. The value 3 is never produced.
- An illegal state encoding recovers to EMPTY on the next edge.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN
- With the macro defined:
  - Extra port stall_cnt, output, 16 bits.
  - Counts cycles with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst only; flush does not affect it.
- Without the macro: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then in_valid=0 -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
- Streaming: out_ready=1; in_data=0x00000001..0x00000008 on consecutive cycles with in_valid=1 -> out_data shows 1..8 on consecutive cycles, 1 cycle later; in_ready stays 1; occupancy=1 throughout.
- Backpressure:
  - out_ready=0; push 0xAAAA0001, 0xAAAA0002 -> occupancy=2, in_ready=0, out_data=0xAAAA0001 held.
  - Third push 0xAAAA0003 is not accepted.
  - Then out_ready=1 -> outputs 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 in order, with no loss or duplication.
- Flush in SKID:
  - With occupancy=2, assert flush with in_valid=1 (data 0x55) -> next cycle out_valid=0, occupancy=0, in_ready=1.
  - 0x55 never appears on out_data.
- Reset mid-operation: occupancy=2, assert rst together with out_ready=1 -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1.
- PIPE_SKID_STALL_CNT_EN:
  - Hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10.
  - Flush leaves it at 10.
  - Force saturation -> stays at 0xFFFF.
  - rst -> 0.
